// File: rtl/mem_router.sv
// Address-decoded memory router: one host port fanned out to N_TGT targets with in-order
// responses, bounded outstanding tracking, decode-error replies and a programming-mode quiesce.
module mem_router #(
   parameter int unsigned         MEM_W    = 32,
   parameter int unsigned         N_TGT    = 4,
   parameter int unsigned         MAX_OUT  = 4,
   parameter logic [N_TGT*32-1:0] TGT_BASE = '0,
   parameter logic [N_TGT*32-1:0] TGT_MASK = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   set_programming_mode,
   output logic                   prog_idle_o,
   input  logic                   host_req_i,
   output logic                   host_gnt_o,
   input  logic [31:0]            host_addr_i,
   input  logic                   host_we_i,
   input  logic [MEM_W/8-1:0]     host_be_i,
   input  logic [MEM_W-1:0]       host_wdata_i,
   output logic                   host_rvalid_o,
   output logic                   host_err_o,
   output logic [MEM_W-1:0]       host_rdata_o,
   output logic [N_TGT-1:0]       tgt_req_o,
   input  logic [N_TGT-1:0]       tgt_gnt_i,
   output logic [31:0]            tgt_addr_o,
   output logic                   tgt_we_o,
   output logic [MEM_W/8-1:0]     tgt_be_o,
   output logic [MEM_W-1:0]       tgt_wdata_o,
   input  logic [N_TGT-1:0]       tgt_rvalid_i,
   input  logic [N_TGT-1:0]       tgt_err_i,
   input  logic [N_TGT*MEM_W-1:0] tgt_rdata_i,
   output logic                   spurious_o
);

   localparam int unsigned TgtW = $clog2(N_TGT + 1);
   localparam int unsigned CntW = $clog2(MAX_OUT + 1);
   localparam logic [TgtW-1:0] Derr   = TgtW'(N_TGT);
   localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUT);
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   logic [CntW-1:0]  out_cnt_q, out_cnt_d;
   logic [TgtW-1:0]  cur_tgt_q, cur_tgt_d;
   logic             derr_pend_q, derr_pend_d;
   logic             prog_q;
   logic             spurious_q, spurious_d;

   logic [TgtW-1:0]  dec_tgt;
   logic             dec_derr;
   logic             cur_derr;
   logic             cnt_nz;
   logic             sel_gnt;
   logic             cur_rvalid;
   logic             cur_err;
   logic [MEM_W-1:0] cur_rdata;
   logic             spur_hit;
   logic             drain_ok;
   logic             issue_ok;

   // Lowest-index match wins: scan downwards so the last hit is the lowest index.
   always_comb begin
      dec_tgt = Derr;
      for (int i = N_TGT - 1; i >= 0; i--) begin
         if ((host_addr_i & TGT_MASK[i*32 +: 32]) == TGT_BASE[i*32 +: 32]) begin
            dec_tgt = TgtW'(i);
         end
      end
   end

   assign dec_derr = (dec_tgt == Derr);
   assign cur_derr = (cur_tgt_q == Derr);
   assign cnt_nz   = (out_cnt_q != '0);

   always_comb begin
      cur_rvalid = 1'b0;
      cur_err    = 1'b0;
      cur_rdata  = '0;
      spur_hit   = 1'b0;
      for (int i = 0; i < N_TGT; i++) begin
         if (cur_tgt_q == TgtW'(i)) begin
            cur_rvalid = tgt_rvalid_i[i];
            cur_err    = tgt_err_i[i];
            cur_rdata  = tgt_rdata_i[i*MEM_W +: MEM_W];
         end
         if (tgt_rvalid_i[i] && ((cur_tgt_q != TgtW'(i)) || !cnt_nz)) begin
            spur_hit = 1'b1;
         end
      end
   end

   always_comb begin
      if (cur_derr) begin
         host_rvalid_o = derr_pend_q;
         host_err_o    = 1'b1;
         host_rdata_o  = '0;
      end else begin
         host_rvalid_o = cur_rvalid & cnt_nz;
         host_err_o    = cur_err & cnt_nz;
         host_rdata_o  = cnt_nz ? cur_rdata : '0;
      end
   end

   // A target switch may proceed in the cycle the last outstanding response drains.
   assign drain_ok = !cnt_nz || (dec_tgt == cur_tgt_q) ||
                     ((out_cnt_q == CntOne) && host_rvalid_o);
   assign issue_ok = host_req_i && !prog_q && (out_cnt_q < CntMax) && drain_ok;

   always_comb begin
      tgt_req_o = '0;
      sel_gnt   = 1'b0;
      for (int i = 0; i < N_TGT; i++) begin
         if (dec_tgt == TgtW'(i)) begin
            tgt_req_o[i] = issue_ok;
            sel_gnt      = tgt_gnt_i[i];
         end
      end
      host_gnt_o = issue_ok & (dec_derr | sel_gnt);
   end

   always_comb begin
      out_cnt_d = out_cnt_q;
      if (host_gnt_o && !host_rvalid_o) begin
         out_cnt_d = out_cnt_q + CntOne;
      end else if (!host_gnt_o && host_rvalid_o) begin
         out_cnt_d = out_cnt_q - CntOne;
      end
      cur_tgt_d   = host_gnt_o ? dec_tgt : cur_tgt_q;
      derr_pend_d = host_gnt_o & dec_derr;
      spurious_d  = spurious_q | spur_hit;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_cnt_q   <= '0;
         cur_tgt_q   <= '0;
         derr_pend_q <= 1'b0;
         prog_q      <= 1'b0;
         spurious_q  <= 1'b0;
      end else begin
         out_cnt_q   <= out_cnt_d;
         cur_tgt_q   <= cur_tgt_d;
         derr_pend_q <= derr_pend_d;
         prog_q      <= set_programming_mode;
         spurious_q  <= spurious_d;
      end
   end

   assign tgt_addr_o  = host_addr_i;
   assign tgt_we_o    = host_we_i;
   assign tgt_be_o    = host_be_i;
   assign tgt_wdata_o = host_wdata_i;
   assign spurious_o  = spurious_q;
   assign prog_idle_o = prog_q & !cnt_nz;

endmodule

// File: tb/tb_mem_router.sv
// Bench for mem_router: per-cycle directed vectors (SRAM=0, GPIO=1, wide overlap=2,
// MAX_OUT=3) followed by hand-written asynchronous-reset and late-response sequences.
module tb_mem_router;

   logic        clk;
   logic        rst;
   logic        set_programming_mode;
   logic        prog_idle_o;
   logic        host_req_i;
   logic        host_gnt_o;
   logic [31:0] host_addr_i;
   logic        host_we_i;
   logic [3:0]  host_be_i;
   logic [31:0] host_wdata_i;
   logic        host_rvalid_o;
   logic        host_err_o;
   logic [31:0] host_rdata_o;
   logic [2:0]  tgt_req_o;
   logic [2:0]  tgt_gnt_i;
   logic [31:0] tgt_addr_o;
   logic        tgt_we_o;
   logic [3:0]  tgt_be_o;
   logic [31:0] tgt_wdata_o;
   logic [2:0]  tgt_rvalid_i;
   logic [2:0]  tgt_err_i;
   logic [95:0] tgt_rdata_i;
   logic        spurious_o;

   mem_router #(
      .MEM_W    (32),
      .N_TGT    (3),
      .MAX_OUT  (3),
      .TGT_BASE ({32'h0000_0000, 32'h1000_0000, 32'h0000_0000}),
      .TGT_MASK ({32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_0000})
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .set_programming_mode (set_programming_mode),
      .prog_idle_o          (prog_idle_o),
      .host_req_i           (host_req_i),
      .host_gnt_o           (host_gnt_o),
      .host_addr_i          (host_addr_i),
      .host_we_i            (host_we_i),
      .host_be_i            (host_be_i),
      .host_wdata_i         (host_wdata_i),
      .host_rvalid_o        (host_rvalid_o),
      .host_err_o           (host_err_o),
      .host_rdata_o         (host_rdata_o),
      .tgt_req_o            (tgt_req_o),
      .tgt_gnt_i            (tgt_gnt_i),
      .tgt_addr_o           (tgt_addr_o),
      .tgt_we_o             (tgt_we_o),
      .tgt_be_o             (tgt_be_o),
      .tgt_wdata_o          (tgt_wdata_o),
      .tgt_rvalid_i         (tgt_rvalid_i),
      .tgt_err_i            (tgt_err_i),
      .tgt_rdata_i          (tgt_rdata_i),
      .spurious_o           (spurious_o)
   );

   typedef struct {
      string       name;
      logic        req;
      logic [31:0] addr;
      logic        we;
      logic [2:0]  tgnt;
      logic [2:0]  trv;
      logic [2:0]  terr;
      logic [31:0] rd;
      logic        prog;
      logic        egnt;
      logic [2:0]  etreq;
      logic        erv;
      logic        eerr;
      logic [31:0] erd;
      logic        espur;
      logic        epidle;
   } vec_t;

   vec_t vq[$];
   int   n_chk;
   int   n_pass;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic add(input string n, input logic req, input logic [31:0] addr, input logic we,
                      input logic [2:0] tgnt, input logic [2:0] trv, input logic [2:0] terr,
                      input logic [31:0] rd, input logic prog, input logic egnt,
                      input logic [2:0] etreq, input logic erv, input logic eerr,
                      input logic [31:0] erd, input logic espur, input logic epidle);
      vec_t v;
      v.name = n; v.req = req; v.addr = addr; v.we = we; v.tgnt = tgnt; v.trv = trv;
      v.terr = terr; v.rd = rd; v.prog = prog; v.egnt = egnt; v.etreq = etreq; v.erv = erv;
      v.eerr = eerr; v.erd = erd; v.espur = espur; v.epidle = epidle;
      vq.push_back(v);
   endtask

   // Non-responding slots carry junk so a wrong response mux shows up.
   task automatic drive(input vec_t v);
      host_req_i           = v.req;
      host_addr_i          = v.addr;
      host_we_i            = v.we;
      host_be_i            = v.we ? 4'h3 : 4'hF;
      host_wdata_i         = v.addr ^ 32'h5A5A_5A5A;
      set_programming_mode = v.prog;
      tgt_gnt_i            = v.tgnt;
      tgt_rvalid_i         = v.trv;
      tgt_err_i            = v.terr;
      for (int i = 0; i < 3; i++) begin
         tgt_rdata_i[i*32 +: 32] = v.trv[i] ? v.rd : (32'hDEAD_0000 | 32'(i));
      end
   endtask

   task automatic check_row(input vec_t v);
      logic [108:0] got;
      logic [108:0] exp;
      got = {host_gnt_o, tgt_req_o, host_rvalid_o, host_err_o & host_rvalid_o,
             host_rvalid_o ? host_rdata_o : 32'h0, spurious_o, prog_idle_o,
             tgt_addr_o, tgt_we_o, tgt_be_o, tgt_wdata_o};
      exp = {v.egnt, v.etreq, v.erv, v.eerr, v.erd, v.espur, v.epidle,
             v.addr, v.we, v.we ? 4'h3 : 4'hF, v.addr ^ 32'h5A5A_5A5A};
      chk(v.name, 128'(got), 128'(exp));
   endtask

   initial begin
      n_chk  = 0;
      n_pass = 0;
      rst    = 1'b1;
      set_programming_mode = 1'b0;
      host_req_i   = 1'b0;
      host_addr_i  = '0;
      host_we_i    = 1'b0;
      host_be_i    = '0;
      host_wdata_i = '0;
      tgt_gnt_i    = '0;
      tgt_rvalid_i = '0;
      tgt_err_i    = '0;
      tgt_rdata_i  = '0;

      // Three back-to-back SRAM reads, 2-cycle latency
      add("idle",   1'b0, 32'h0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      add("b2b_g0", 1'b1, 32'h0000_0010, 1'b0, 3'b001, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b1, 3'b001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      add("b2b_g1", 1'b1, 32'h0000_0014, 1'b0, 3'b001, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b1, 3'b001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      add("b2b_g2", 1'b1, 32'h0000_0018, 1'b0, 3'b001, 3'b001, 3'b000, 32'h10, 1'b0,
          1'b1, 3'b001, 1'b1, 1'b0, 32'h10, 1'b0, 1'b0);
      add("b2b_r1", 1'b0, 32'h0, 1'b0, 3'b000, 3'b001, 3'b000, 32'h14, 1'b0,
          1'b0, 3'b000, 1'b1, 1'b0, 32'h14, 1'b0, 1'b0);
      add("b2b_r2", 1'b0, 32'h0, 1'b0, 3'b000, 3'b001, 3'b000, 32'h18, 1'b0,
          1'b0, 3'b000, 1'b1, 1'b0, 32'h18, 1'b0, 1'b0);
      add("b2b_end", 1'b0, 32'h0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      // SRAM read then GPIO write: switch held until the SRAM response cycle
      add("sw_sram", 1'b1, 32'h0000_0020, 1'b0, 3'b001, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b1, 3'b001, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      add("sw_hold", 1'b1, 32'h1000_0004, 1'b1, 3'b010, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      add("sw_go",  1'b1, 32'h1000_0004, 1'b1, 3'b010, 3'b001, 3'b000, 32'h20, 1'b0,
          1'b1, 3'b010, 1'b1, 1'b0, 32'h20, 1'b0, 1'b0);
      add("gpio_err", 1'b0, 32'h0, 1'b0, 3'b000, 3'b010, 3'b010, 32'h0, 1'b0,
          1'b0, 3'b000, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
      // Unmapped address -> decode error one cycle later
      add("derr_g", 1'b1, 32'h8000_0000, 1'b0, 3'b111, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      add("derr_r", 1'b0, 32'h0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b0, 3'b000, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
      add("derr_done", 1'b0, 32'h0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      // Overlapping regions: 0x0000_0040 hits 0 and 2, lowest index wins
      add("t2_g",   1'b1, 32'h0100_0000, 1'b0, 3'b100, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b1, 3'b100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      add("prio_hold", 1'b1, 32'h0000_0040, 1'b0, 3'b111, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      add("t2_r",   1'b0, 32'h0, 1'b0, 3'b000, 3'b100, 3'b000, 32'h200, 1'b0,
          1'b0, 3'b000, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0);
      // Fill to MAX_OUT=3 on slow GPIO, full+response blocks, then regrant
      add("full_g0", 1'b1, 32'h1000_0008, 1'b0, 3'b010, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b1, 3'b010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      add("full_g1", 1'b1, 32'h1000_0008, 1'b0, 3'b010, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b1, 3'b010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      add("full_g2", 1'b1, 32'h1000_0008, 1'b0, 3'b010, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b1, 3'b010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      add("full_stall", 1'b1, 32'h1000_0008, 1'b0, 3'b010, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      add("full_rsp", 1'b1, 32'h1000_0008, 1'b0, 3'b010, 3'b010, 3'b000, 32'hA1, 1'b0,
          1'b0, 3'b000, 1'b1, 1'b0, 32'hA1, 1'b0, 1'b0);
      add("full_regnt", 1'b1, 32'h1000_0008, 1'b0, 3'b010, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b1, 3'b010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      add("full_r2", 1'b0, 32'h0, 1'b0, 3'b000, 3'b010, 3'b000, 32'hA2, 1'b0,
          1'b0, 3'b000, 1'b1, 1'b0, 32'hA2, 1'b0, 1'b0);
      add("tgt_nognt", 1'b1, 32'h1000_0008, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b0, 3'b010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      add("full_r3", 1'b0, 32'h0, 1'b0, 3'b000, 3'b010, 3'b000, 32'hA3, 1'b0,
          1'b0, 3'b000, 1'b1, 1'b0, 32'hA3, 1'b0, 1'b0);
      add("full_r4", 1'b0, 32'h0, 1'b0, 3'b000, 3'b010, 3'b000, 32'hA4, 1'b0,
          1'b0, 3'b000, 1'b1, 1'b0, 32'hA4, 1'b0, 1'b0);
      // Spurious response with nothing outstanding; flag is registered and sticky
      add("spur_inj", 1'b0, 32'h0, 1'b0, 3'b000, 3'b010, 3'b000, 32'h55, 1'b0,
          1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      add("spur_set", 1'b0, 32'h0, 1'b0, 3'b000, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      // Programming mode with two outstanding
      add("pm_g0",  1'b1, 32'h1000_0000, 1'b0, 3'b010, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b1, 3'b010, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      add("pm_g1",  1'b1, 32'h1000_0000, 1'b0, 3'b010, 3'b000, 3'b000, 32'h0, 1'b1,
          1'b1, 3'b010, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      add("pm_block", 1'b1, 32'h1000_0000, 1'b0, 3'b010, 3'b000, 3'b000, 32'h0, 1'b1,
          1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      add("pm_r0",  1'b1, 32'h1000_0000, 1'b0, 3'b010, 3'b010, 3'b000, 32'hB1, 1'b1,
          1'b0, 3'b000, 1'b1, 1'b0, 32'hB1, 1'b1, 1'b0);
      add("pm_r1",  1'b1, 32'h1000_0000, 1'b0, 3'b010, 3'b010, 3'b000, 32'hB2, 1'b1,
          1'b0, 3'b000, 1'b1, 1'b0, 32'hB2, 1'b1, 1'b0);
      add("pm_idle", 1'b1, 32'h1000_0000, 1'b0, 3'b010, 3'b000, 3'b000, 32'h0, 1'b1,
          1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      add("pm_exit", 1'b1, 32'h1000_0000, 1'b0, 3'b010, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      add("pm_resume", 1'b1, 32'h1000_0000, 1'b0, 3'b010, 3'b000, 3'b000, 32'h0, 1'b0,
          1'b1, 3'b010, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      add("pm_rsp", 1'b0, 32'h0, 1'b0, 3'b000, 3'b010, 3'b000, 32'hC1, 1'b0,
          1'b0, 3'b000, 1'b1, 1'b0, 32'hC1, 1'b1, 1'b0);

      @(negedge clk);
      chk("reset", 128'({host_gnt_o, tgt_req_o, host_rvalid_o, spurious_o, prog_idle_o}),
          128'(0));
      @(posedge clk);
      #1 rst = 1'b0;

      foreach (vq[i]) begin
         @(posedge clk);
         #1 drive(vq[i]);
         @(negedge clk);
         check_row(vq[i]);
      end

      // Reset mid-operation: one SRAM read outstanding, then asynchronous reset
      @(posedge clk);
      #1;
      host_req_i   = 1'b1;
      host_addr_i  = 32'h0000_0010;
      host_we_i    = 1'b0;
      tgt_gnt_i    = 3'b001;
      tgt_rvalid_i = 3'b000;
      @(negedge clk);
      chk("pre_rst_gnt", 128'(host_gnt_o), 128'(1));
      @(posedge clk);
      #1;
      host_req_i = 1'b0;
      tgt_gnt_i  = 3'b000;
      #2 rst = 1'b1;
      #1 chk("async_rst", 128'({spurious_o, prog_idle_o, host_rvalid_o, tgt_req_o}), 128'(0));
      @(posedge clk);
      #1;
      rst               = 1'b0;
      tgt_rvalid_i      = 3'b001;
      tgt_rdata_i[31:0] = 32'h77;
      @(negedge clk);
      chk("late_rsp_drop", 128'({host_rvalid_o, spurious_o}), 128'(0));
      @(posedge clk);
      #1 tgt_rvalid_i = 3'b000;
      @(negedge clk);
      chk("late_rsp_spur", 128'(spurious_o), 128'(1));
      @(posedge clk);
      #1;
      host_req_i  = 1'b1;
      host_addr_i = 32'h1000_0000;
      tgt_gnt_i   = 3'b010;
      @(negedge clk);
      chk("post_rst_gnt", 128'({host_gnt_o, tgt_req_o}), 128'(4'b1010));
      @(posedge clk);
      #1;
      host_req_i = 1'b0;
      tgt_gnt_i  = 3'b000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("spur_sticky", 128'(spurious_o), 128'(1));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
